// File: rtl/mem_access_pkg.sv
// mem_access_pkg: FSM states, funct3 size codes and access-legality helpers for the load/store unit.
package mem_access_pkg;
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_WB, S_FAULT} state_t;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam int TIMEOUT_DEFAULT = 255;
  function automatic logic f3_ok(input logic is_load, input logic [2:0] f3);
    return is_load ? (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU)
                   : (f3 == F3_B || f3 == F3_H || f3 == F3_W);
  endfunction
  // Only meaningful for supported funct3: bit1 marks word, bit0 marks half.
  function automatic logic aligned(input logic [2:0] f3, input logic [1:0] a);
    return f3[1] ? (a == 2'b00) : f3[0] ? !a[0] : 1'b1;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store-lane replication with strobes, and load-lane select with sign/zero extension.
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_offset,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_wdata,
  output logic [3:0]      o_wstrb,
  output logic [XLEN-1:0] o_load_data
);
  logic [XLEN-1:0] w_shift;
  assign w_shift = i_rdata >> {i_offset, 3'b000};
  always_comb begin
    o_wdata     = i_funct3[1] ? i_store_data
                : i_funct3[0] ? {(XLEN/16){i_store_data[15:0]}} : {(XLEN/8){i_store_data[7:0]}};
    o_wstrb     = i_funct3[1] ? 4'b1111
                : i_funct3[0] ? (i_offset[1] ? 4'b1100 : 4'b0011) : 4'b0001 << i_offset;
    o_load_data = i_funct3[1] ? w_shift
                : i_funct3[0] ? {{(XLEN-16){w_shift[15] & !i_funct3[2]}}, w_shift[15:0]}
                              : {{(XLEN-8){w_shift[7] & !i_funct3[2]}}, w_shift[7:0]};
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: load/store unit running single-beat bus transactions with stall, writeback and fault reporting.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic [XLEN-1:0] load_addr,
  input  logic [4:0]      load_regs_addr,
  input  logic            store_en,
  input  logic [XLEN-1:0] store_addr,
  input  logic [XLEN-1:0] store_data,
  input  logic [2:0]      funct3,
  output logic            hold,
  output logic            regs_write_en,
  output logic [4:0]      regs_write_addr,
  output logic [XLEN-1:0] regs_write_data,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_wstrb,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata,
  output logic            access_fault
);
  state_t          r_state, w_next;
  logic [XLEN-1:0] r_addr, r_data, r_rdata;
  logic [2:0]      r_f3;
  logic [4:0]      r_rd;
  logic            r_we;
  logic [7:0]      r_cnt;
  logic            w_ok, w_timeout, w_bus, w_st, w_wb;
  logic [XLEN-1:0] w_wdata, w_load;
  logic [3:0]      w_wstrb;
  assign w_ok = (load_en ^ store_en) && f3_ok(load_en, funct3)
             && aligned(funct3, load_en ? load_addr[1:0] : store_addr[1:0]);
  assign w_timeout = r_cnt == 8'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // An ack in the final wait cycle still wins over the timeout.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = w_ok ? S_BUS : (load_en | store_en) ? S_FAULT : S_IDLE;
      S_BUS:   w_next = bus_ack ? (r_we ? S_IDLE : S_WB) : w_timeout ? S_FAULT : S_BUS;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_rdata <= '0;
      r_f3    <= 3'd0;
      r_rd    <= 5'd0;
      r_we    <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      if (r_state == S_IDLE && w_ok) begin
        r_we   <= store_en;
        r_addr <= store_en ? store_addr : load_addr;
        r_data <= store_data;
        r_f3   <= funct3;
        r_rd   <= load_en ? load_regs_addr : 5'd0;
      end
      if (r_state == S_BUS && bus_ack && !r_we) r_rdata <= bus_rdata;
      r_cnt <= (r_state == S_BUS && w_next == S_BUS) ? r_cnt + 8'd1 : 8'd0;
    end
  end
  mem_lane_align #(.XLEN(XLEN)) u_align (
    .i_funct3    (r_f3),
    .i_offset    (r_addr[1:0]),
    .i_store_data(r_data),
    .i_rdata     (r_rdata),
    .o_wdata     (w_wdata),
    .o_wstrb     (w_wstrb),
    .o_load_data (w_load)
  );
  assign w_bus = r_state == S_BUS;
  assign w_st  = w_bus & r_we;
  assign w_wb  = r_state == S_WB;
  always_comb begin
    hold            = r_state == S_IDLE ? (load_en | store_en) : w_bus;
    bus_req         = w_bus;
    bus_we          = w_st;
    bus_addr        = w_bus ? {r_addr[XLEN-1:2], 2'b00} : '0;
    bus_wdata       = w_st ? w_wdata : '0;
    bus_wstrb       = w_st ? w_wstrb : 4'b0000;
    regs_write_en   = w_wb && r_rd != 5'd0;
    regs_write_addr = w_wb ? r_rd : 5'd0;
    regs_write_data = w_wb ? w_load : '0;
    access_fault    = r_state == S_FAULT;
  end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Load/store unit on the far side of the execute stage.
- Takes the load/store requests that execute emits (enable, address, data, destination register, funct3) and runs them as single-beat word-bus transactions with ready/ack handshaking.
- Handles byte-lane steering, strobe generation and sign/zero extension for LB/LH/LW/LBU/LHU/SB/SH/SW.
- Returns load data to the register-file write port and stalls the pipeline while a transaction is in flight.

Parameters:
- XLEN, 32, data/address width.
- TIMEOUT, 255, maximum cycles to wait for bus_ack before aborting (8-bit counter, 1..255).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- load_en  in  1  load request from execute.
- load_addr  in  XLEN  load byte address.
- load_regs_addr  in  5  destination register.
- store_en  in  1  store request from execute.
- store_addr  in  XLEN  store byte address.
- store_data  in  XLEN  store data (rs2 value).
- funct3  in  3  access size/sign (inst[14:12]).
- hold  out  1  pipeline stall request.
- regs_write_en  out  1  register-file write enable.
- regs_write_addr  out  5  register-file write address.
- regs_write_data  out  XLEN  extended load data.
- bus_req  out  1  bus request valid.
- bus_we  out  1  1 = write.
- bus_addr  out  XLEN  word address, bits [1:0] forced to 0.
- bus_wdata  out  XLEN  lane-replicated write data.
- bus_wstrb  out  4  byte strobes.
- bus_ack  in  1  bus completion.
- bus_rdata  in  XLEN  read data, valid with bus_ack.
- access_fault  out  1  one-cycle pulse on a misaligned, conflicting or timed-out access.

Behaviour:
- Reset: state IDLE. All outputs 0. Timeout counter 0. Captured request registers 0.
- Reset has priority over every transition. An ack arriving in the reset cycle is ignored, and bus_req is 0 from the next cycle.
- States are IDLE, BUS, WB, FAULT.
- IDLE:
  - hold = load_en | store_en, combinational.
  - On an edge with exactly one enable high and the access aligned: capture the address, data, funct3 and rd, then go to BUS.
  - Alignment rules: word needs addr[1:0]==0; half needs addr[0]==0; byte is always aligned.
  - Misaligned access, both enables high, or an unsupported funct3 (load 3/6/7, store 3..7): go to FAULT; no bus access.
- BUS:
  - bus_req=1; bus_addr/bus_we/bus_wdata/bus_wstrb are held stable until ack; hold=1.
  - Stores: SB replicates byte 0 to all four lanes, strobe 1<<addr[1:0]. SH replicates the low half, strobe 0011 or 1100. SW uses strobe 1111.
  - Loads: bus_wstrb=0.
  - On bus_ack, sampled at the edge: a load captures bus_rdata and goes to WB; a store goes to IDLE.
  - Without an ack, the counter increments. At counter==TIMEOUT-1 with no ack, go to FAULT and drop bus_req the next cycle.
  - The counter clears on leaving BUS.
- WB (one cycle):
  - regs_write_en=1 only if rd!=0.
  - regs_write_addr=rd.
  - regs_write_data is the selected lane, extended per funct3: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - hold=0, so the load retires and the pipeline advances this cycle. Next state is IDLE.
- FAULT (one cycle): access_fault=1, hold=0, no register write. Next state is IDLE.
- Minimum latencies:
  - Load: request edge, then ≥1 BUS cycle, then 1 WB cycle, so hold is high for ≥2 cycles.
  - Store: hold is high for ≥1 cycle after capture.
- Enables in WB or FAULT are not accepted. Execute re-presents them after hold drops.

Decomposition:
- Shared constants file: state encodings, the funct3 load/store size codes already used by the instruction decode, and the default TIMEOUT.
- One natural sub-module, mem_lane_align: combinational store-lane replication with strobe generation, plus load-lane select with sign/zero extension. It can be unit-tested alone.

Test Plan:
- LB from 0x1003, bus_rdata=0x80FF_1234 acked after 2 wait cycles: bus_addr=0x1000, wstrb=0; in WB, regs_write_data=0xFFFFFF80 to rd; hold low in the WB cycle.
- SH of 0x0000ABCD to 0x2002, ack immediate: bus_we=1, bus_wdata=0xABCDABCD, bus_wstrb=4'b1100; no register write; back to IDLE.
- LW from 0x3001: no bus_req; access_fault pulses one cycle; regs_write_en stays 0.
- LBU from 0x4002, rd=0, rdata=0x00AA0000: bus access occurs; regs_write_en stays 0 in WB.
- Load with bus_ack never asserted, TIMEOUT=4: bus_req high for exactly 4 cycles, then access_fault one cycle, then IDLE.
- rst asserted during BUS with ack in the same cycle: all outputs 0 next cycle; no register write; next load completes normally.
